// File: rtl/farm_sensor_ctrl.sv
// Farm-road car request generator: synchronises and debounces the vehicle
// detector, latches a request, tracks service by the farm green and flags starvation.
module farm_sensor_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000,
  parameter int unsigned WAIT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sensor_raw,
  input  logic [2:0] light_farm,
  output logic       C,
  output logic       starve,
  output logic [7:0] served_count,
  output logic       light_err
);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PENDING, SERVING} state_e;

  localparam logic [7:0]        CNT_LAST     = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_TIMEOUT = WAIT_W'(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_ONE     = WAIT_W'(1);

  state_e            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [7:0]        cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [7:0]        served_q, served_d;
  logic              lerr_q;
  logic              s, green, onehot;

  assign s      = sync2_q;
  assign green  = (light_farm == 3'b001);
  assign onehot = (light_farm == 3'b100) || (light_farm == 3'b010) || (light_farm == 3'b001);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      wait_q   <= '0;
      served_q <= '0;
      lerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync1_q  <= sensor_raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      served_q <= served_d;
      lerr_q   <= ~onehot;
    end
  end

  // cnt_q is the debounce count in DEBOUNCE and the departure (clear) count in SERVING
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    served_d = served_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) begin
          state_d = DEBOUNCE;
          cnt_d   = 8'd1;
        end
      end
      DEBOUNCE: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PENDING;
          cnt_d   = '0;
          wait_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      PENDING: begin
        if (green) begin
          state_d = SERVING;
          cnt_d   = '0;
          if (served_q != '1) served_d = served_q + 8'd1;
        end else if (wait_q != '1) begin
          wait_d = wait_q + WAIT_ONE;
        end
      end
      SERVING: begin
        cnt_d = s ? '0 : cnt_q + 8'd1;
        if (!green || (!s && cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign C            = (state_q == PENDING) || (state_q == SERVING);
  assign starve       = (state_q == PENDING) && (wait_q >= WAIT_TIMEOUT);
  assign served_count = served_q;
  assign light_err    = lerr_q;

endmodule

// File: tb/tb_farm_sensor_ctrl.sv
// Bench for farm_sensor_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a request/service reference model.
module tb_farm_sensor_ctrl;

  localparam int DB = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sensor_raw = 1'b0;
  logic [2:0] light_farm = 3'b100;
  logic       C, starve, light_err;
  logic [7:0] served_count;

  int checks = 0;
  int errors = 0;

  farm_sensor_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_CYCLES (TO),
    .WAIT_W         (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sensor_raw  (sensor_raw),
    .light_farm  (light_farm),
    .C           (C),
    .starve      (starve),
    .served_count(served_count),
    .light_err   (light_err)
  );

  always #5 clk = ~clk;

  // Reference model: raw history, request flag, service flag and the run lengths
  bit m_h1, m_h2, m_req, m_serv, m_lerr;
  int m_run, m_wait, m_quiet, m_served;

  task automatic model_edge(input bit r, input bit raw, input logic [2:0] lf);
    bit s, grn;
    if (!r) begin
      m_h1 = 0; m_h2 = 0; m_req = 0; m_serv = 0; m_lerr = 0;
      m_run = 0; m_wait = 0; m_quiet = 0; m_served = 0;
      return;
    end
    s   = m_h2;
    grn = (lf == 3'b001);
    if (!m_req) begin
      m_run = s ? m_run + 1 : 0;
      if (m_run == DB) begin
        m_req = 1; m_serv = 0; m_wait = 0; m_run = 0;
      end
    end else if (!m_serv) begin
      if (grn) begin
        m_serv = 1; m_quiet = 0;
        if (m_served < 255) m_served++;
      end else if (m_wait < 65535) begin
        m_wait++;
      end
    end else begin
      m_quiet = s ? 0 : m_quiet + 1;
      if (!grn || m_quiet == DB) begin
        m_req = 0; m_serv = 0; m_run = 0;
      end
    end
    m_lerr = ($countones(lf) != 1);
    m_h2 = m_h1;
    m_h1 = raw;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic raw, input logic [2:0] lf);
    rst_n      = r;
    sensor_raw = raw;
    light_farm = lf;
    @(posedge clk);
    model_edge(r, raw, lf);
    #1;
    chk("m_C",      {31'd0, C},         {31'd0, m_req});
    chk("m_starve", {31'd0, starve},    {31'd0, (m_req && !m_serv && m_wait >= TO)});
    chk("m_served", {24'd0, served_count}, m_served);
    chk("m_lerr",   {31'd0, light_err}, {31'd0, m_lerr});
  endtask

  task automatic do_reset();
    step(0, 0, 3'b100);
    step(0, 0, 3'b100);
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (C !== 1'b1 && k < 20) begin
      step(1, 1, 3'b100);
      k++;
    end
    chk(tag, {31'd0, C}, 32'd1);
  endtask

  initial begin
    bit          raw_r;
    int          hold;
    logic [2:0]  lf_r;
    int unsigned sel;

    // reset held with detector high and green on
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 3'b001);
      chk("rst_C", {31'd0, C}, 32'd0);
      chk("rst_served", {24'd0, served_count}, 32'd0);
    end
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 3'b001);
      chk("rst_rise", {31'd0, C}, {31'd0, (i == 6)});
    end

    // bouncing detector never reaches a request
    do_reset();
    begin
      bit pat [7] = '{1, 1, 0, 1, 1, 1, 0};
      foreach (pat[i]) begin
        step(1, pat[i], 3'b100);
        chk("bounce_noC", {31'd0, C}, 32'd0);
      end
    end
    for (int i = 1; i <= 6; i++) begin
      step(1, 1, 3'b100);
      chk("bounce_rise", {31'd0, C}, {31'd0, (i == 6)});
    end

    // serve, then departure detected while green stays on
    step(1, 1, 3'b001);
    chk("serve_C", {31'd0, C}, 32'd1);
    chk("serve_cnt", {24'd0, served_count}, 32'd1);
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 3'b001);
      chk("depart_fall", {31'd0, C}, {31'd0, (i < 6)});
    end

    // starvation
    do_reset();
    wait_req("starve_req");
    for (int j = 1; j <= 25; j++) begin
      step(1, 1, 3'b100);
      chk("starve_lvl", {31'd0, starve}, {31'd0, (j >= TO)});
    end
    step(1, 1, 3'b001);
    chk("starve_clr", {31'd0, starve}, 32'd0);
    chk("starve_C", {31'd0, C}, 32'd1);

    // departure completes on the same edge as an illegal lamp code
    for (int i = 1; i <= 5; i++) step(1, (i >= 5), 3'b001);
    step(1, 1, 3'b011);
    chk("sim_C", {31'd0, C}, 32'd0);
    chk("sim_lerr", {31'd0, light_err}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step(1, 1, 3'b100);
      if (k == 1) chk("sim_lerr_once", {31'd0, light_err}, 32'd0);
      chk("sim_rereq", {31'd0, C}, {31'd0, (k == 4)});
    end

    // served_count saturation, then reset mid-request
    do_reset();
    for (int n = 0; n < 260; n++) begin
      wait_req("sat_req");
      step(1, 1, 3'b001);
      step(1, 1, 3'b100);
    end
    chk("sat_served", {24'd0, served_count}, 32'd255);
    wait_req("sat_pend");
    step(0, 1, 3'b100);
    chk("midrst_C", {31'd0, C}, 32'd0);
    chk("midrst_served", {24'd0, served_count}, 32'd0);

    // randomized traffic against the model
    raw_r = 0;
    hold  = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        raw_r = $urandom_range(0, 1) == 1;
        hold  = $urandom_range(1, 12);
      end
      hold--;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 9: lf_r = 3'b100;
        3:          lf_r = 3'b010;
        8:          lf_r = 3'($urandom_range(0, 7));
        default:    lf_r = 3'b001;
      endcase
      step(($urandom_range(0, 299) != 0), raw_r, lf_r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/farm_sensor_ctrl.md
Name: farm_sensor_ctrl

Overview:
- Produces the traffic-light controller's farm-road car request `C` from a raw, bouncy vehicle detector.
- Synchronises and debounces the detector, then latches a request.
- Watches `light_farm` to learn when the request has been served, and flags starvation if service takes too long.
- Sits between the detector pin and the controller, in the same clock domain as the controller.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive equal synchronised samples required to accept a level change; legal range 2..255.
- TIMEOUT_CYCLES, 1000: cycles spent in PENDING before `starve` asserts; must be ≥1 and < 2^WAIT_W.
- WAIT_W, 16: width of the wait counter.

Ports:
- clk  input  1  controller clock
- rst_n  input  1  synchronous reset, active low
- sensor_raw  input  1  raw vehicle detector, asynchronous, may bounce
- light_farm  input  3  farm-road lamp state, one-hot {red,yellow,green}: 3'b100 red, 3'b010 yellow, 3'b001 green
- C  output  1  car request to the controller
- starve  output  1  request waited ≥ TIMEOUT_CYCLES without green
- served_count  output  8  number of requests that reached green, saturating
- light_err  output  1  one-cycle pulse when light_farm is not one-hot

Behaviour:
- Reset:
  - Synchronous, active-low: sampled on rising clk while rst_n=0.
  - Result: state=IDLE, synchroniser flops=0, all counters=0, C=0, starve=0, served_count=0, light_err=0.
  - Reset asserted mid-operation drops C on the following cycle, with no other side effects.
- Synchroniser: two flops; the FSM sees `s` = sensor_raw delayed by 2 edges.
- FSM is Moore: C=1 exactly when state ∈ {PENDING, SERVING}.
- `green` = (light_farm==3'b001).
- Any non-one-hot light_farm value:
  - light_err=1 for that cycle (registered, so it appears the next cycle).
  - The value is treated as not green.
- IDLE:
  - debounce count=0.
  - s=1 → DEBOUNCE with count=1.
- DEBOUNCE:
  - s=0 → IDLE.
  - s=1 and count==DEBOUNCE_CYCLES-1 → PENDING, wait=0.
  - Otherwise count++.
  - Latency: C rises on the (DEBOUNCE_CYCLES+2)th rising edge after sensor_raw goes high and stays high.
- PENDING:
  - green → SERVING; served_count++ (saturates at 255); starve cleared.
  - Otherwise wait++ (saturating at 2^WAIT_W-1).
  - starve=1 from the cycle wait reaches TIMEOUT_CYCLES and stays set while in PENDING.
  - sensor_raw dropping in PENDING does NOT cancel the request: the vehicle is waiting behind the stop line.
- SERVING:
  - Tracks departure: clear count resets to 0 whenever s=1 and increments when s=0.
  - green deasserts (yellow, red, or illegal) → IDLE.
  - clear count reaches DEBOUNCE_CYCLES → IDLE (vehicles gone).
  - If both happen in the same cycle → IDLE; served_count is unchanged.
- Re-request: returning to IDLE with s still 1 starts a fresh DEBOUNCE on the next cycle. A new request therefore needs a full debounce again.
- Green already on when PENDING is entered: transition to SERVING on the next edge. served_count counts it.
- starve is 0 in every state except PENDING.

Test Plan (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20):
- Reset: hold rst_n=0 for 3 cycles with sensor_raw=1 and light_farm=3'b001 → C=0, starve=0, served_count=0 throughout. After release, C rises 6 edges later.
- Bounce: sensor_raw pattern 1,1,0,1,1,1,0 per cycle, light_farm=red → C never asserts. Then hold 1 → C=1 exactly 6 edges after the last 0→1 transition.
- Serve: request pending, drive light_farm=3'b001 → next edge state=SERVING, served_count=1. Drop sensor_raw → C falls (DEBOUNCE_CYCLES+2)=6 edges later while green is still on.
- Starvation: request pending with light_farm=red for 25 cycles → starve rises on the 20th PENDING cycle and stays 1. Green → starve=0 on the next cycle, C stays 1.
- Simultaneous/illegal:
  - In SERVING, drive light_farm=3'b011 on the same cycle the clear count hits 4 → light_err pulses once, FSM goes to IDLE, C=0.
  - Then, with sensor_raw still 1, C re-asserts 4 edges later (no synchroniser delay, since the synchronised level is already high).
- Saturation: 260 complete serve cycles → served_count ends at 255 with no wrap. Reset mid-PENDING → C=0 on the next cycle, served_count=0.
